// File: rtl/laser_pkg.sv
// laser_pkg -- shared definitions for the LASER feeder slice.
// Holds the default pattern size, core-reset length and RUN timeout,
// the controller state encoding and the point type.
package laser_pkg;

    localparam int unsigned NPTS       = 40;
    localparam int unsigned RST_CYCLES = 2;
    localparam int unsigned MAX_CYCLES = 500000;

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        SEND,
        RUN,
        SCORE,
        REPORT
    } state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } point_t;

endpackage

// File: rtl/laser_cover_unit.sv
// laser_cover_unit -- combinational coverage test for one point.
// Ports:
//   PT      point under test
//   C1, C2  the two candidate centres
//   COVERED high when PT lies within squared distance 16 of either centre
module laser_cover_unit
    import laser_pkg::*;
(
    input  point_t PT,
    input  point_t C1,
    input  point_t C2,
    output logic   COVERED
);

    // Squared Euclidean distance; differences are 5-bit two's complement,
    // squares 8-bit, sum 9-bit, so nothing is ever truncated.
    function automatic logic [8:0] dist2(input point_t a, input point_t b);
        logic [4:0] dx;
        logic [4:0] dy;
        logic [3:0] ax;
        logic [3:0] ay;
        logic [7:0] sx;
        logic [7:0] sy;
        dx = {1'b0, a.x} - {1'b0, b.x};
        dy = {1'b0, a.y} - {1'b0, b.y};
        // Magnitude always fits in 4 bits since |d| <= 15.
        ax = dx[4] ? 4'(-dx) : dx[3:0];
        ay = dy[4] ? 4'(-dy) : dy[3:0];
        sx = {4'd0, ax} * {4'd0, ax};
        sy = {4'd0, ay} * {4'd0, ay};
        return {1'b0, sx} + {1'b0, sy};
    endfunction

    always_comb begin
        COVERED = (dist2(PT, C1) <= 9'd16) || (dist2(PT, C2) <= 9'd16);
    end

endmodule

// File: rtl/laser_feeder.sv
// laser_feeder -- loads a point pattern, drives it into the LASER core,
// waits for the core result and scores how many points the two result
// centres cover.
// Ports:
//   CLK, RST                    clock, asynchronous active-low reset
//   LD_VALID/LD_X/LD_Y/LD_READY point loading (IDLE only)
//   LD_CLR                      clear the load count
//   START, BUSY                 run request / controller not idle
//   CORE_RST, X, Y              core reset and streamed point
//   CORE_DONE, C1X..C2Y         core completion and result centres
//   RES_VALID, RES_*            one-cycle result pulse and captured centres
//   COVER, CYCLES, ERR          covered count, RUN cycles, error flags
module laser_feeder #(
    parameter int unsigned NPTS       = laser_pkg::NPTS,
    parameter int unsigned RST_CYCLES = laser_pkg::RST_CYCLES,
    parameter int unsigned MAX_CYCLES = laser_pkg::MAX_CYCLES
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LD_VALID,
    input  logic [3:0]  LD_X,
    input  logic [3:0]  LD_Y,
    output logic        LD_READY,
    input  logic        LD_CLR,
    input  logic        START,
    output logic        BUSY,
    output logic        CORE_RST,
    output logic [3:0]  X,
    output logic [3:0]  Y,
    input  logic        CORE_DONE,
    input  logic [3:0]  C1X,
    input  logic [3:0]  C1Y,
    input  logic [3:0]  C2X,
    input  logic [3:0]  C2Y,
    output logic        RES_VALID,
    output logic [3:0]  RES_C1X,
    output logic [3:0]  RES_C1Y,
    output logic [3:0]  RES_C2X,
    output logic [3:0]  RES_C2Y,
    output logic [5:0]  COVER,
    output logic [19:0] CYCLES,
    output logic [1:0]  ERR
);
    import laser_pkg::*;

    localparam int unsigned CW = $clog2(NPTS + 1);
    localparam int unsigned IW = $clog2(NPTS);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] ld_cnt;
    logic [19:0]   cnt;
    point_t        mem [NPTS];
    point_t        rd_pt;
    point_t        c1_q;
    point_t        c2_q;
    logic [5:0]    cover_q;
    logic [19:0]   cycles_q;
    logic [1:0]    err_q;
    logic          covered;
    logic          start_ok;
    logic          ld_wr;
    logic          run_end;

    assign start_ok = START && !LD_CLR && (ld_cnt == CW'(NPTS));
    assign ld_wr    = (state == IDLE) && LD_VALID && !LD_CLR && (ld_cnt < CW'(NPTS));
    assign run_end  = CORE_DONE || (cnt > 20'(MAX_CYCLES));
    // cnt doubles as the point index in SEND and SCORE.
    assign rd_pt    = mem[cnt[IW-1:0]];

    laser_cover_unit u_cover (
        .PT      (rd_pt),
        .C1      (c1_q),
        .C2      (c2_q),
        .COVERED (covered)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        LD_READY  = 1'b0;
        BUSY      = (state != IDLE);
        CORE_RST  = 1'b0;
        X         = '0;
        Y         = '0;
        RES_VALID = 1'b0;
        case (state)
            IDLE: begin
                LD_READY = (ld_cnt < CW'(NPTS));
                if (start_ok) state_nx = CRST;
            end
            CRST: begin
                CORE_RST = 1'b1;
                if (cnt == 20'(RST_CYCLES - 1)) state_nx = SEND;
            end
            SEND: begin
                X = rd_pt.x;
                Y = rd_pt.y;
                if (CORE_DONE)                 state_nx = REPORT;
                else if (cnt == 20'(NPTS - 1)) state_nx = RUN;
            end
            RUN:    if (run_end) state_nx = SCORE;
            SCORE:  if (cnt == 20'(NPTS - 1)) state_nx = REPORT;
            REPORT: begin
                RES_VALID = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Buffer RAM: no reset so it can map to memory.
    always_ff @(posedge CLK) begin
        if (ld_wr) mem[ld_cnt[IW-1:0]] <= {LD_X, LD_Y};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ld_cnt   <= '0;
            cnt      <= '0;
            c1_q     <= '0;
            c2_q     <= '0;
            cover_q  <= '0;
            cycles_q <= '0;
            err_q    <= '0;
        end else begin
            // Per-state counter restarts on every state change.
            if (state == IDLE || state_nx != state) cnt <= '0;
            else                                     cnt <= cnt + 20'd1;

            case (state)
                IDLE: begin
                    if (LD_CLR)     ld_cnt <= '0;
                    else if (ld_wr) ld_cnt <= ld_cnt + CW'(1);
                    if (start_ok) begin
                        c1_q     <= '0;
                        c2_q     <= '0;
                        cover_q  <= '0;
                        cycles_q <= '0;
                        err_q    <= '0;
                    end
                end
                SEND: begin
                    if (CORE_DONE) begin
                        err_q[0] <= 1'b1;
                        cover_q  <= '0;
                        cycles_q <= '0;
                    end
                end
                RUN: begin
                    if (run_end) begin
                        c1_q     <= {C1X, C1Y};
                        c2_q     <= {C2X, C2Y};
                        cycles_q <= cnt;
                        if (!CORE_DONE) err_q[1] <= 1'b1;
                    end
                end
                SCORE: begin
                    if (covered) cover_q <= cover_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign RES_C1X = c1_q.x;
    assign RES_C1Y = c1_q.y;
    assign RES_C2X = c2_q.x;
    assign RES_C2Y = c2_q.y;
    assign COVER   = cover_q;
    assign CYCLES  = cycles_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_laser_feeder.sv
// tb_laser_feeder -- randomized self-checking bench for laser_feeder.
// The reference model keeps the loaded pattern in plain arrays and derives
// stream contents, result latency and coverage counts arithmetically.
module tb_laser_feeder;

    localparam int NP   = 40;
    localparam int MAXC = 200;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        LD_VALID = 1'b0;
    logic [3:0]  LD_X = '0;
    logic [3:0]  LD_Y = '0;
    logic        LD_CLR = 1'b0;
    logic        START = 1'b0;
    logic        CORE_DONE = 1'b0;
    logic [3:0]  C1X = '0;
    logic [3:0]  C1Y = '0;
    logic [3:0]  C2X = '0;
    logic [3:0]  C2Y = '0;
    logic        LD_READY;
    logic        BUSY;
    logic        CORE_RST;
    logic [3:0]  X;
    logic [3:0]  Y;
    logic        RES_VALID;
    logic [3:0]  RES_C1X;
    logic [3:0]  RES_C1Y;
    logic [3:0]  RES_C2X;
    logic [3:0]  RES_C2Y;
    logic [5:0]  COVER;
    logic [19:0] CYCLES;
    logic [1:0]  ERR;

    int checks = 0;
    int errors = 0;
    int bx [NP];
    int by [NP];
    int mcnt = 0;

    always #5 CLK = ~CLK;

    laser_feeder #(
        .NPTS       (NP),
        .RST_CYCLES (2),
        .MAX_CYCLES (MAXC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .LD_VALID  (LD_VALID),
        .LD_X      (LD_X),
        .LD_Y      (LD_Y),
        .LD_READY  (LD_READY),
        .LD_CLR    (LD_CLR),
        .START     (START),
        .BUSY      (BUSY),
        .CORE_RST  (CORE_RST),
        .X         (X),
        .Y         (Y),
        .CORE_DONE (CORE_DONE),
        .C1X       (C1X),
        .C1Y       (C1Y),
        .C2X       (C2X),
        .C2Y       (C2Y),
        .RES_VALID (RES_VALID),
        .RES_C1X   (RES_C1X),
        .RES_C1Y   (RES_C1Y),
        .RES_C2X   (RES_C2X),
        .RES_C2Y   (RES_C2Y),
        .COVER     (COVER),
        .CYCLES    (CYCLES),
        .ERR       (ERR)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int cover_model(input int c1x, input int c1y, input int c2x, input int c2y);
        int n = 0;
        for (int i = 0; i < NP; i++) begin
            if ((bx[i]-c1x)*(bx[i]-c1x) + (by[i]-c1y)*(by[i]-c1y) <= 16 ||
                (bx[i]-c2x)*(bx[i]-c2x) + (by[i]-c2y)*(by[i]-c2y) <= 16)
                n++;
        end
        return n;
    endfunction

    // All tasks start and end at a falling clock edge.
    task automatic load_pt(input int x, input int y);
        LD_VALID = 1'b1;
        LD_X = 4'(x);
        LD_Y = 4'(y);
        if (mcnt < NP) begin
            bx[mcnt] = x;
            by[mcnt] = y;
            mcnt++;
        end
        @(negedge CLK);
        LD_VALID = 1'b0;
    endtask

    task automatic clear_load();
        LD_CLR = 1'b1;
        @(negedge CLK);
        LD_CLR = 1'b0;
        mcnt = 0;
        check_eq("clr_ready", int'(LD_READY), 1);
    endtask

    // mode 0: DONE at RUN cycle dc; mode 1: never DONE; mode 2: DONE at SEND cycle dc
    task automatic do_run(input int mode, input int dc,
                          input int c1x, input int c1y, input int c2x, input int c2y);
        int n, t, exp_t, exp_cov, exp_err, exp_cyc, exp_c, xy_bad;
        bit got;
        C1X = 4'(c1x); C1Y = 4'(c1y); C2X = 4'(c2x); C2Y = 4'(c2y);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check_eq("busy_on_start", int'(BUSY), 1);
        check_eq("res_clr_on_start", int'({ERR, COVER, CYCLES}), 0);
        n = 0;
        while (CORE_RST && n < 10) begin
            n++;
            CORE_DONE = 1'($urandom_range(0, 1));   // must be ignored here
            @(negedge CLK);
        end
        check_eq("crst_len", n, 2);
        xy_bad = 0;
        got = 1'b0;
        for (t = 0; t < NP + MAXC + 100; t++) begin
            CORE_DONE = (mode == 2 && t == dc) || (mode == 0 && t == NP + dc);
            if (t < NP && !(mode == 2 && t > dc)) begin
                if (X !== 4'(bx[t]) || Y !== 4'(by[t])) xy_bad++;
            end else if (X !== 4'd0 || Y !== 4'd0) begin
                xy_bad++;
            end
            if (RES_VALID) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        CORE_DONE = 1'b0;
        check_eq("xy_stream", xy_bad, 0);
        check_eq("res_seen", int'(got), 1);
        exp_c = (c1x << 12) | (c1y << 8) | (c2x << 4) | c2y;
        exp_cyc = dc;
        exp_cov = cover_model(c1x, c1y, c2x, c2y);
        case (mode)
            0: begin exp_t = NP + dc + 1 + NP;   exp_err = 0; end
            1: begin exp_t = NP + MAXC + 2 + NP; exp_err = 2; end
            default: begin
                exp_t = dc + 1; exp_err = 1; exp_cov = 0; exp_cyc = 0; exp_c = 0;
            end
        endcase
        check_eq("res_latency", t, exp_t);
        check_eq("err", int'(ERR), exp_err);
        check_eq("cover", int'(COVER), exp_cov);
        check_eq("centres", int'({RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}), exp_c);
        if (mode != 1) check_eq("cycles", int'(CYCLES), exp_cyc);
        @(negedge CLK);
        check_eq("res_pulse", int'({RES_VALID, BUSY}), 0);
        check_eq("cover_hold", int'(COVER), exp_cov);
    endtask

    initial begin
        int bad;
        // reset state
        repeat (3) @(negedge CLK);
        check_eq("rst_busy", int'({BUSY, CORE_RST, RES_VALID}), 0);
        check_eq("rst_xy", int'({X, Y}), 0);
        check_eq("rst_results", int'({ERR, COVER, CYCLES}), 0);
        check_eq("rst_centres", int'({RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}), 0);
        check_eq("rst_ready", int'(LD_READY), 1);
        RST = 1'b1;
        @(negedge CLK);

        // boundary: distance^2 16 covered, 18 not covered
        for (int i = 0; i < NP; i++) load_pt(0, 0);
        check_eq("ld_full", int'(LD_READY), 0);
        do_run(0, 20, 4, 0, 15, 15);
        check_eq("cover_d16", int'(COVER), 40);
        clear_load();
        for (int i = 0; i < NP; i++) load_pt(3, 3);
        do_run(0, 5, 0, 0, 15, 15);
        check_eq("cover_d18", int'(COVER), 0);

        // 40x(5,5), DONE after 100 RUN cycles
        clear_load();
        for (int i = 0; i < NP; i++) load_pt(5, 5);
        do_run(0, 100, 5, 5, 0, 0);
        check_eq("basic_cover", int'(COVER), 40);
        check_eq("basic_cycles", int'(CYCLES), 100);

        // DONE during the 10th SEND cycle, re-START without reload
        do_run(2, 9, 5, 5, 0, 0);
        check_eq("send_done_err", int'(ERR), 1);

        // timeout with random centres
        do_run(1, 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

        // randomized patterns
        for (int r = 0; r < 5; r++) begin
            LD_CLR = 1'b1;
            START  = 1'b1;
            @(negedge CLK);
            LD_CLR = 1'b0;
            START  = 1'b0;
            mcnt = 0;
            check_eq("clr_beats_start", int'({BUSY, LD_READY}), 1);
            for (int i = 0; i < NP + int'($urandom_range(0, 3)); i++)
                load_pt(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            check_eq("rand_full", int'(LD_READY), 0);
            do_run(0, int'($urandom_range(0, MAXC)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            if (r == 2)
                do_run(0, int'($urandom_range(0, 30)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        // START with 39 points is ignored
        clear_load();
        for (int i = 0; i < NP - 1; i++) load_pt(int'($urandom_range(0, 15)), 7);
        check_eq("ready_39", int'(LD_READY), 1);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (BUSY !== 1'b0) bad++;
            @(negedge CLK);
        end
        check_eq("start_39_ignored", bad, 0);

        // reset pulsed mid-SEND
        load_pt(9, 9);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("mid_send_x", int'(X), bx[1]);
        RST = 1'b0;
        #1;
        check_eq("mid_rst_out", int'({BUSY, CORE_RST, RES_VALID, X, Y}), 0);
        @(negedge CLK);
        RST = 1'b1;
        mcnt = 0;
        @(negedge CLK);
        check_eq("mid_rst_ready", int'(LD_READY), 1);
        for (int i = 0; i < NP - 1; i++) load_pt(1, 1);
        check_eq("cnt_rst_39", int'(LD_READY), 1);
        load_pt(1, 1);
        check_eq("cnt_rst_40", int'(LD_READY), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/laser_feeder.md
LASER_FEEDER -- requirements
Module: laser_feeder

Interface
REQ-001 Parameters (name, default, meaning): NPTS, 40, points per pattern; RST_CYCLES, 2, core-reset cycles; MAX_CYCLES, 500000, RUN timeout.
REQ-002 CLK  in  1  single clock; all logic on rising edge.
REQ-003 RST  in  1  asynchronous, active-low reset.
REQ-004 LD_VALID  in  1  write one point into the buffer this cycle.
REQ-005 LD_X, LD_Y  in  4 each  point coordinates.
REQ-006 LD_READY  out  1  high in IDLE while fewer than NPTS points are loaded.
REQ-007 LD_CLR  in  1  clears the load count (buffer contents not required to clear).
REQ-008 START  in  1  run request; accepted only in IDLE with NPTS points loaded.
REQ-009 BUSY  out  1  high in every state except IDLE.
REQ-010 CORE_RST  out  1  active-high reset to the LASER core.
REQ-011 X, Y  out  4 each  point streamed to the core.
REQ-012 CORE_DONE  in  1  core completion.
REQ-013 C1X, C1Y, C2X, C2Y  in  4 each  core result centres.
REQ-014 RES_VALID  out  1  one-cycle result pulse.
REQ-015 RES_C1X, RES_C1Y, RES_C2X, RES_C2Y  out  4 each  captured centres.
REQ-016 COVER  out  6  covered-point count, 0..40.
REQ-017 CYCLES  out  20  RUN cycles before DONE.
REQ-018 ERR  out  2  bit0 = DONE during SEND; bit1 = timeout.

Function
REQ-019 States: IDLE, CRST, SEND, RUN, SCORE, REPORT.
REQ-020 IDLE: each LD_VALID with LD_READY high writes buffer[count] and increments count; LD_VALID with LD_READY low is ignored.
REQ-021 LD_CLR and START in the same cycle: LD_CLR wins and START is ignored; START with count < NPTS is ignored.
REQ-022 Accepted START -> CRST; CORE_RST is high for exactly RST_CYCLES cycles, then -> SEND.
REQ-023 SEND: X/Y = buffer[k] during the k-th SEND cycle, k = 0..NPTS-1, one point per cycle with no gaps; then -> RUN.
REQ-024 X/Y = 0 in every state except SEND.
REQ-025 CORE_DONE is ignored in CRST.
REQ-026 CORE_DONE = 1 in any SEND cycle: set ERR[0], COVER = 0, CYCLES = 0, -> REPORT.
REQ-027 RUN: cycle counter clears on entry and increments each cycle CORE_DONE = 0.
REQ-028 CORE_DONE = 1 in RUN: capture C1X/C1Y/C2X/C2Y and the counter, -> SCORE.
REQ-029 Counter > MAX_CYCLES in RUN: capture the core outputs as they stand, set ERR[1], -> SCORE.
REQ-030 SCORE: one point per cycle for NPTS cycles; point i is covered iff (dx1²+dy1² ≤ 16) or (dx2²+dy2² ≤ 16).
REQ-031 Differences are signed 5-bit, squares are 8-bit unsigned, sums are 9-bit; no truncation.
REQ-032 SCORE then -> REPORT; REPORT asserts RES_VALID for one cycle, then -> IDLE.
REQ-033 RES_*, COVER, CYCLES and ERR hold their values until the next accepted START, which clears them.
REQ-034 Buffer and load count persist across runs, so re-START without reload is legal.

Reset
REQ-035 RST low -> IDLE and load count 0.
REQ-036 RST low -> CORE_RST = 0, X/Y = 0, RES_VALID = 0, BUSY = 0, all result registers 0; effective immediately, including mid-run.
REQ-037 Buffer RAM contents are not reset.

Structure
REQ-038 laser_pkg holds: NPTS, RST_CYCLES, MAX_CYCLES, the state enum, and a point typedef (4-bit x, 4-bit y).
REQ-039 Sub-module laser_cover_unit: combinational, one point and two centres in, covered bit out.

Verification
REQ-040 Load 40×(5,5); core model asserts DONE 100 cycles into RUN with C1 = (5,5), C2 = (0,0) -> RES_VALID, COVER = 40, CYCLES = 100, ERR = 0.
REQ-041 Core model never asserts DONE -> RES_VALID after MAX_CYCLES+1 RUN cycles, ERR = 2'b10, COVER computed from the sampled centres.
REQ-042 Core model asserts DONE on the 10th SEND cycle -> ERR = 2'b01, COVER = 0, RES_VALID one cycle later.
REQ-043 Point (0,0) with C1 = (4,0) -> covered; point (3,3) with C1 = (0,0) (distance² 18) and C2 = (15,15) -> not covered.
REQ-044 START with 39 points loaded -> BUSY stays 0; RST pulsed low mid-SEND -> IDLE, X/Y = 0, load count 0.
